// File: rtl/hex_pkg.sv
// -----------------------------------------------------------------------------
// hex_pkg
// Types and constants shared by the seven-segment scan controller and its
// hex decoder.
//   seg_t     : 7-bit active-low segment pattern, bit order {g,f,e,d,c,b,a}
//   nibble_t  : one hex digit
//   SEG_BLANK : all segments off
// -----------------------------------------------------------------------------
package hex_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage : hex_pkg

// File: rtl/hex_display.sv
// -----------------------------------------------------------------------------
// hex_display
// Combinational hex-to-seven-segment decoder with active-low outputs.
// Ports:
//   hex : nibble to display (0-F)
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_display
    import hex_pkg::*;
(
    input  nibble_t hex,
    output seg_t    seg
);

    always_comb begin
        // NOTE: a default before the case means every path assigns seg, so
        // no latch can be inferred even if the case is edited later.
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : hex_display

// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS seven-segment display.
// One hex_display decoder is shared across all digits. New values arrive on
// a valid/ready handshake into a one-entry pending register and are copied
// into the displayed (shadow) value only at a frame boundary, so a frame
// never shows a mix of old and new digits.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   load_valid : load_data is valid this cycle
//   load_ready : a new value can be accepted (pending register empty)
//   load_data  : packed nibbles, nibble i = digit i, digit 0 least significant
//   blank_lz   : 1 = blank leading-zero digits (digit 0 is never blanked)
//   seg        : registered active-low segment pattern
//   digit_en   : registered active-low one-cold digit enable
//   frame_done : one-cycle pulse in the cycle the last digit's slot ends
// -----------------------------------------------------------------------------
module hex_scan_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lz,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;

    logic                    tick;
    logic                    frame_end;
    logic                    xfer;
    nibble_t                 cur_nib;
    seg_t                    dec_seg;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    blank;

    assign tick       = (cnt == CNT_LAST);
    assign frame_end  = tick && (idx == IDX_LAST);
    assign frame_done = frame_end;

    // load_ready is the complement of a flop, so it is glitch-free and
    // depends only on state, never on load_valid.
    assign load_ready = !pending_full;
    assign xfer       = load_valid && !pending_full;

    // Refresh counter and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Handshake and frame-boundary commit. A transfer needs pending empty,
    // so it can never coincide with a commit; data accepted on a boundary
    // cycle waits for the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            pending_full <= 1'b0;
            shadow       <= '0;
        end else if (xfer) begin
            pending      <= load_data;
            pending_full <= 1'b1;
        end else if (frame_end && pending_full) begin
            shadow       <= pending;
            pending_full <= 1'b0;
        end
    end

    // Nibble of the digit currently being scanned.
    assign cur_nib = shadow[{idx, 2'b00} +: 4];

    hex_display u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero, i.e.
    // digit i is a leading zero.
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = ((shadow >> (4 * i)) == '0);
        end
    end

    assign blank = blank_lz && (idx != '0) && upper_zero[idx];

    // seg and digit_en come from the same edge, so a digit never shows a
    // neighbour's pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg      <= SEG_BLANK;
            digit_en <= '1;
        end else begin
            seg      <= blank ? SEG_BLANK : dec_seg;
            digit_en <= ~(NUM_DIGITS'(1) << idx);
        end
    end

endmodule : hex_scan_ctrl

// File: tb/tb_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_ctrl
// Self-checking bench for hex_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hex_scan_ctrl;
    import hex_pkg::*;

    localparam int ND = 4;
    localparam int RD = 4;

    localparam seg_t H0 = 7'b1000000, H1 = 7'b1111001, H2 = 7'b0100100,
                     H3 = 7'b0110000, H4 = 7'b0011001, H5 = 7'b0010010,
                     H6 = 7'b0000010, H7 = 7'b1111000, H8 = 7'b0000000,
                     H9 = 7'b0010000, HA = 7'b0001000, HB = 7'b0000011,
                     HC = 7'b1000110, HD = 7'b0100001, HE = 7'b0000110,
                     HF = 7'b0001110, BLK = 7'b1111111;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [4*ND-1:0] load_data;
    logic            blank_lz;
    seg_t            seg;
    logic [ND-1:0]   digit_en;
    logic            frame_done;

    hex_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     data;
        logic            blz;
        logic [3:0][6:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [9];

    logic [3:0] en_exp [4];

    int n_checks = 0;
    int n_fail   = 0;
    int off      = 0;   // falling edges since the last frame_done

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        off++;
    endtask

    task automatic wait_fd(input string name);
        for (int k = 0; k < 40; k++) begin
            nxt();
            if (frame_done) break;
        end
        check({name, " frame_done"}, 32'(frame_done), 32'd1);
        off = 0;
    endtask

    // Digit d is displayed on falling edges off = 2+4d .. 5+4d after the
    // frame_done edge; sample each in the middle of its slot.
    task automatic sample_frame(input logic [3:0][6:0] exp, input string name);
        for (int d = 0; d < 4; d++) begin
            while (off < 3 + 4 * d) nxt();
            check($sformatf("%s seg d%0d", name, d), 32'(seg), 32'(exp[d]));
            check($sformatf("%s en d%0d", name, d), 32'(digit_en), 32'(en_exp[d]));
        end
    endtask

    task automatic do_load(input logic [15:0] v, input string name);
        check({name, " ready before"}, 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = v;
        nxt();
        check({name, " ready after"}, 32'(load_ready), 32'd0);
        load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        en_exp[0] = 4'b1110;
        en_exp[1] = 4'b1101;
        en_exp[2] = 4'b1011;
        en_exp[3] = 4'b0111;

        vecs[0] = '{16'h1A3F, 1'b0, {H1,  HA,  H3,  HF}};
        vecs[1] = '{16'h0005, 1'b1, {BLK, BLK, BLK, H5}};
        vecs[2] = '{16'h0000, 1'b1, {BLK, BLK, BLK, H0}};
        vecs[3] = '{16'h0000, 1'b0, {H0,  H0,  H0,  H0}};
        vecs[4] = '{16'h0F00, 1'b1, {BLK, HF,  H0,  H0}};
        vecs[5] = '{16'h8000, 1'b1, {H8,  H0,  H0,  H0}};
        vecs[6] = '{16'h2B6D, 1'b0, {H2,  HB,  H6,  HD}};
        vecs[7] = '{16'h79E4, 1'b1, {H7,  H9,  HE,  H4}};
        vecs[8] = '{16'h0010, 1'b1, {BLK, BLK, H1,  H0}};

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        blank_lz   = 1'b0;

        // 1. Reset values, then the free-running scan with shadow 0.
        #12;
        check("rst seg", 32'(seg), 32'(BLK));
        check("rst en", 32'(digit_en), 32'hF);
        check("rst ready", 32'(load_ready), 32'd1);
        check("rst fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check($sformatf("scan en k%0d", k), 32'(digit_en), 32'(en_exp[((k - 1) / 4) % 4]));
            check($sformatf("scan fd k%0d", k), 32'(frame_done), 32'((k % 16) == 15));
            check($sformatf("scan seg k%0d", k), 32'(seg), 32'(H0));
        end
        off = 1;

        // 2. Single load: held in pending until the frame boundary.
        do_load(16'h1A3F, "t2");
        check("t2 seg unchanged", 32'(seg), 32'(H0));
        wait_fd("t2");
        sample_frame({H1, HA, H3, HF}, "t2");
        check("t2 ready back", 32'(load_ready), 32'd1);

        // 3. Back-to-back loads with valid held: the second stalls until
        //    the first commits.
        wait_fd("t3 align");
        nxt();
        load_valid = 1'b1;
        load_data  = 16'h1111;
        nxt();
        check("t3 first taken", 32'(load_ready), 32'd0);
        load_data  = 16'h2222;
        wait_fd("t3");
        check("t3 stalled at fd", 32'(load_ready), 32'd0);
        nxt();
        check("t3 ready after commit", 32'(load_ready), 32'd1);
        nxt();
        check("t3 second taken", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        sample_frame({H1, H1, H1, H1}, "t3 first");
        wait_fd("t3b");
        sample_frame({H2, H2, H2, H2}, "t3 second");

        // 4. Transfer on the frame_done cycle commits one frame later.
        wait_fd("t4");
        check("t4 ready on fd", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 16'h00C5;
        nxt();
        check("t4 taken", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        sample_frame({H2, H2, H2, H2}, "t4 old");
        wait_fd("t4b");
        sample_frame({H0, H0, HC, H5}, "t4 new");

        // 5. Table of values and blanking modes.
        for (int v = 0; v < 9; v++) begin
            blank_lz = vecs[v].blz;
            do_load(vecs[v].data, $sformatf("vec%0d", v));
            wait_fd($sformatf("vec%0d", v));
            sample_frame(vecs[v].exp, $sformatf("vec%0d", v));
        end

        // 6. Reset mid-frame with a value pending: it must be discarded.
        blank_lz = 1'b0;
        wait_fd("t6 align");
        nxt();
        do_load(16'hBEEF, "t6");
        nxt();
        nxt();
        #2 reset = 1'b1;
        #1;
        check("t6 rst seg", 32'(seg), 32'(BLK));
        check("t6 rst en", 32'(digit_en), 32'hF);
        check("t6 rst ready", 32'(load_ready), 32'd1);
        check("t6 rst fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nxt();
        check("t6 restart en", 32'(digit_en), 32'(en_exp[0]));
        check("t6 restart seg", 32'(seg), 32'(H0));
        check("t6 restart ready", 32'(load_ready), 32'd1);
        wait_fd("t6a");
        sample_frame({H0, H0, H0, H0}, "t6 frame1");
        wait_fd("t6b");
        sample_frame({H0, H0, H0, H0}, "t6 frame2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hex_scan_ctrl

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit seven-segment display. It shares one hex_display decoder instance across NUM_DIGITS digits. It walks a digit index at a fixed refresh rate and drives the active-low segment and digit-enable lines. New display values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  controller can accept a new value
load_data  input  4*NUM_DIGITS  packed nibbles; nibble i = digit i, digit 0 = least significant
blank_lz  input  1  1 = blank leading-zero digits
seg  output  7  active-low segment pattern, decoder bit order
digit_en  output  NUM_DIGITS  active-low one-cold digit enable
frame_done  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous and active-high.
- Reset values:
  - seg = 7'b1111111; digit_en = all ones (all digits off); load_ready = 1; frame_done = 0.
  - Internal: shadow value = 0, pending empty, digit index = 0, refresh counter = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (counter == REFRESH_DIV-1).
  - On tick, the digit index advances i -> i+1; NUM_DIGITS-1 wraps to 0.
- Frame boundary: a tick while index == NUM_DIGITS-1.
  - frame_done = 1 for exactly that cycle.
- Load handshake:
  - Transfer occurs when load_valid && load_ready.
  - load_data is captured into the pending register and pending_full is set.
  - load_ready = !pending_full (registered).
  - load_valid while load_ready = 0 is ignored; no data loss on the controller's side, the requester holds.
- Commit:
  - At a frame boundary with pending_full = 1: shadow <= pending, pending_full clears, load_ready returns to 1 on the next cycle.
  - With pending empty, shadow is held.
- Simultaneous transfer and frame boundary in the same cycle:
  - Pending was empty that cycle, so the new data goes to pending only.
  - It commits at the following frame boundary; there is no bypass.
- Leading-zero blanking:
  - Digit i (i >= 1) is blank when blank_lz = 1 and nibbles i..NUM_DIGITS-1 of shadow are all zero.
  - Digit 0 is never blanked.
  - Blank means seg = 7'b1111111; digit_en still strobes normally.
- Output timing:
  - seg and digit_en are registered from the current index and shadow.
  - They lag the index by 1 cycle. digit_en and seg always change in the same cycle, so no ghosting.
- digit_en: exactly one bit is 0 at all times after the first post-reset edge. Bit index = displayed digit.
- Nibble decode:
  - 0-F use the hex_display patterns, e.g. 0 -> 7'b1000000, A -> 7'b0001000.
- Reset asserted mid-frame:
  - All state returns to reset values immediately.
  - Any pending value is discarded.
  - Scanning restarts at digit 0 with shadow 0.

Decomposition:
- Shared package (hex_pkg):
  - SEG_BLANK = 7'b1111111.
  - Typedef seg_t (logic [6:0]).
  - Typedef nibble_t (logic [3:0]).
- Sub-module: one hex_display instance as the shared combinational decoder, fed by the muxed shadow nibble.
- Blanking override and output registers stay in hex_scan_ctrl.

Test Plan:
1. Reset, then run with NUM_DIGITS=4, REFRESH_DIV=4 -> seg=7F and digit_en=1111 during reset; afterwards digit_en cycles 1110,1101,1011,0111, 4 cycles each; frame_done pulses every 16 cycles; digits show 0 (1000000).
2. Load 16'h1A3F while ready, then wait -> load_ready drops the next cycle; display unchanged until frame_done; then digits 0..3 show F(0001110), 3(0110000), A(0001000), 1(1111001); load_ready returns to 1.
3. Back-to-back loads 16'h1111 then 16'h2222 held valid -> second load stalls (load_ready=0) until the commit, is accepted after it, and displays one frame later; no value is skipped.
4. Load asserted exactly on the frame_done cycle with 16'h00C5 -> not shown in the current frame; shown after the next frame boundary.
5. blank_lz=1 with shadow 16'h0005 -> digits 3,2,1 seg=1111111 and digit 0 shows 5 (0010010). Shadow 16'h0000 -> only digit 0 shows 0. blank_lz=0 -> all digits show 0.
6. Reset asserted mid-frame with pending 16'hBEEF -> outputs go to reset values asynchronously; after release the display shows 0000 and BEEF never appears.
